// File: rtl/way_hit_select_pkg.sv
// Shared cache parameters and helpers used by the lookup datapath and the cache controller.
package way_hit_select_pkg;

    localparam int WAYS_DEF            = 4;
    localparam int TAG_BITS_DEF        = 18;
    localparam int LINE_SIZE_BYTES_DEF = 64;
    localparam int LINE_BITS           = LINE_SIZE_BYTES_DEF * 8;

    // Widest way vector lsb_onehot handles; callers zero-extend narrower vectors.
    localparam int MAX_WAYS = 32;

    // Isolate the lowest set bit: result is one-hot, or zero when v is zero.
    function automatic logic [MAX_WAYS-1:0] lsb_onehot(input logic [MAX_WAYS-1:0] v);
        return v & (~v + MAX_WAYS'(1));
    endfunction

endpackage

// File: rtl/way_hit_select_mux.sv
// AND-OR one-hot line selector; unselected ways are masked to zero before the OR.
module onehot_data_mux #(
    parameter int WAYS      = 4,
    parameter int LINE_BITS = 512
) (
    input  logic [WAYS-1:0]           sel_i,
    input  logic [WAYS*LINE_BITS-1:0] data_i,
    output logic [LINE_BITS-1:0]      data_o
);

    always_comb begin
        data_o = '0;
        for (int w = 0; w < WAYS; w++) begin
            data_o = data_o | (data_i[w*LINE_BITS +: LINE_BITS] & {LINE_BITS{sel_i[w]}});
        end
    end

endmodule

// File: rtl/way_hit_select.sv
// Registered hit-detect and line-select stage for the set-associative cache.
// One lookup per cycle, result one cycle after i_req; outputs hold while idle.
module way_hit_select
    import way_hit_select_pkg::*;
#(
    parameter int WAYS            = WAYS_DEF,
    parameter int TAG_BITS        = TAG_BITS_DEF,
    parameter int LINE_SIZE_BYTES = LINE_SIZE_BYTES_DEF,
    localparam int LINE_W         = LINE_SIZE_BYTES * 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_req,
    input  logic [TAG_BITS-1:0]      i_tag,
    input  logic [WAYS*TAG_BITS-1:0] i_way_tags,
    input  logic [WAYS-1:0]          i_way_valid,
    input  logic [WAYS*LINE_W-1:0]   i_way_data,
    output logic                     o_valid,
    output logic                     o_cache_hit,
    output logic [WAYS-1:0]          o_hit_way,
    output logic                     o_multi_hit,
    output logic [LINE_W-1:0]        o_data
);

    logic [WAYS-1:0]   match;
    logic [WAYS-1:0]   sel;
    logic              multi;
    logic [LINE_W-1:0] data_sel;

    logic              valid_q;
    logic              hit_q,   hit_d;
    logic [WAYS-1:0]   way_q,   way_d;
    logic              multi_q, multi_d;
    logic [LINE_W-1:0] data_q,  data_d;

    for (genvar w = 0; w < WAYS; w++) begin : g_cmp
        assign match[w] = (i_way_tags[w*TAG_BITS +: TAG_BITS] == i_tag) & i_way_valid[w];
    end

    // Lowest-index way wins on a multi-hit, so sel stays one-hot for the mux.
    assign sel   = WAYS'(lsb_onehot(MAX_WAYS'(match)));
    assign multi = ($countones(match) > 1);

    onehot_data_mux #(
        .WAYS      (WAYS),
        .LINE_BITS (LINE_W)
    ) u_mux (
        .sel_i  (sel),
        .data_i (i_way_data),
        .data_o (data_sel)
    );

    always_comb begin
        hit_d   = hit_q;
        way_d   = way_q;
        multi_d = multi_q;
        data_d  = data_q;
        if (i_req) begin
            hit_d   = |match;
            way_d   = sel;
            multi_d = multi;
            data_d  = data_sel;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            hit_q   <= 1'b0;
            way_q   <= '0;
            multi_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= i_req;
            hit_q   <= hit_d;
            way_q   <= way_d;
            multi_q <= multi_d;
            data_q  <= data_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_cache_hit = hit_q;
    assign o_hit_way   = way_q;
    assign o_multi_hit = multi_q;
    assign o_data      = data_q;

endmodule

// File: tb/tb_way_hit_select.sv
// Scoreboard bench for way_hit_select: directed cases plus random lookups vs. a way-scan model.
module tb_way_hit_select;

    localparam int WAYS = 4;
    localparam int TB   = 18;
    localparam int LB   = 512;

    typedef struct {
        logic          v;
        logic          hit;
        logic [3:0]    way;
        logic          multi;
        logic [LB-1:0] data;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 req = 1'b0;
    logic [TB-1:0]        tag = '0;
    logic [WAYS*TB-1:0]   tags = '0;
    logic [WAYS-1:0]      vld = '0;
    logic [WAYS*LB-1:0]   data = '0;
    logic                 o_valid, o_cache_hit, o_multi_hit;
    logic [WAYS-1:0]      o_hit_way;
    logic [LB-1:0]        o_data;

    exp_t q[$];
    int   n_vec = 0;
    int   n_bad = 0;
    bit   mon_en = 1'b0;

    // Model state: what the outputs should hold while idle.
    logic          m_hit = 1'b0;
    logic [3:0]    m_way = '0;
    logic          m_multi = 1'b0;
    logic [LB-1:0] m_data = '0;

    always #5 clk = ~clk;

    way_hit_select dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req       (req),
        .i_tag       (tag),
        .i_way_tags  (tags),
        .i_way_valid (vld),
        .i_way_data  (data),
        .o_valid     (o_valid),
        .o_cache_hit (o_cache_hit),
        .o_hit_way   (o_hit_way),
        .o_multi_hit (o_multi_hit),
        .o_data      (o_data)
    );

    task automatic check(input string name, input logic [LB-1:0] act, input logic [LB-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WAYS*LB-1:0] rand_data();
        logic [WAYS*LB-1:0] d;
        for (int i = 0; i < WAYS*LB/32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    // Drive one cycle of stimulus and push the model's expected registered result.
    task automatic drive(input logic r, input logic [TB-1:0] t, input logic [WAYS*TB-1:0] wt,
                         input logic [WAYS-1:0] wv, input logic [WAYS*LB-1:0] wd);
        int   first;
        int   cnt;
        exp_t e;
        @(negedge clk);
        req  = r;
        tag  = t;
        tags = wt;
        vld  = wv;
        data = wd;
        first = -1;
        cnt   = 0;
        for (int w = 0; w < WAYS; w++) begin
            if (wv[w] && wt[w*TB +: TB] == t) begin
                cnt++;
                if (first < 0) first = w;
            end
        end
        if (r) begin
            m_hit   = (first >= 0);
            m_way   = (first >= 0) ? 4'(1 << first) : 4'b0;
            m_multi = (cnt > 1);
            m_data  = (first >= 0) ? wd[first*LB +: LB] : '0;
        end
        e.v = r; e.hit = m_hit; e.way = m_way; e.multi = m_multi; e.data = m_data;
        q.push_back(e);
    endtask

    always @(posedge clk) begin
        #1;
        if (mon_en && q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            check("valid", LB'(o_valid), LB'(e.v));
            check("cache_hit", LB'(o_cache_hit), LB'(e.hit));
            check("hit_way", LB'(o_hit_way), LB'(e.way));
            check("multi_hit", LB'(o_multi_hit), LB'(e.multi));
            check("data", o_data, e.data);
        end
    end

    initial begin
        logic [WAYS*TB-1:0] wt;
        logic [WAYS*LB-1:0] wd;
        logic [TB-1:0]      pool [4];
        int                 guard;

        // Reset state
        #12;
        check("rst_valid", LB'(o_valid), '0);
        check("rst_hit", LB'(o_cache_hit), '0);
        check("rst_way", LB'(o_hit_way), '0);
        check("rst_data", o_data, '0);
        @(negedge clk);
        rst_n = 1'b1;
        mon_en = 1'b1;

        // Single hit on way 1
        wt = {18'h12345, 18'h3FFFF, 18'h2A5C3, 18'h00001};
        wd = rand_data();
        wd[1*LB +: LB] = {16{32'hDEADBEEF}};
        drive(1'b1, 18'h2A5C3, wt, 4'b1111, wd);
        // Matching tag in an invalid way is a miss
        drive(1'b1, 18'h2A5C3, wt, 4'b1101, wd);
        // Multi-hit: ways 1 and 3 share a tag
        wt = {18'h00ABC, 18'h11111, 18'h00ABC, 18'h22222};
        wd = rand_data();
        drive(1'b1, 18'h00ABC, wt, 4'b1111, wd);
        // Back-to-back hit on way 3, miss, then idle cycles holding the miss
        wt = {18'h3A3A3, 18'h01010, 18'h02020, 18'h03030};
        wd = rand_data();
        drive(1'b1, 18'h3A3A3, wt, 4'b1111, wd);
        drive(1'b1, 18'h00777, wt, 4'b1111, rand_data());
        drive(1'b0, 18'h3A3A3, wt, 4'b1111, rand_data());
        drive(1'b0, 18'h01010, wt, 4'b1111, rand_data());

        // Random lookups with a small tag pool to provoke hits and multi-hits
        for (int i = 0; i < 4; i++) pool[i] = TB'($urandom);
        for (int n = 0; n < 300; n++) begin
            for (int w = 0; w < WAYS; w++) wt[w*TB +: TB] = pool[$urandom_range(0, 3)];
            drive(($urandom_range(0, 3) != 0), pool[$urandom_range(0, 3)], wt,
                  4'($urandom), rand_data());
        end

        guard = 0;
        while (q.size() > 0 && guard < 20) begin
            @(posedge clk);
            guard++;
        end
        #2;
        check("queue_drained", LB'(q.size()), '0);
        mon_en = 1'b0;

        // Mid-lookup async reset: get a known hit on the outputs first
        wt = {18'h00004, 18'h00003, 18'h00002, 18'h00001};
        wd = rand_data();
        drive(1'b1, 18'h00003, wt, 4'b1111, wd);
        @(posedge clk);
        #1;
        check("pre_rst_hit", LB'(o_hit_way), LB'(4'b0100));
        @(negedge clk);
        req = 1'b1;
        tag = 18'h00002;
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", LB'(o_valid), '0);
        check("async_hit", LB'(o_cache_hit), '0);
        check("async_way", LB'(o_hit_way), '0);
        check("async_multi", LB'(o_multi_hit), '0);
        check("async_data", o_data, '0);
        @(posedge clk);
        #1;
        check("rst_hold_valid", LB'(o_valid), '0);
        @(negedge clk);
        req = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_valid", LB'(o_valid), '0);
        check("post_rst_data", o_data, '0);
        @(posedge clk);
        #1;
        check("post_rst_valid2", LB'(o_valid), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
